csi_rx_packet_handler: RTL and testbench

- Sits directly upstream of the RAW10 unpacker, downstream of the lane merger / word aligner.
- Takes byte-aligned 32-bit words for one CSI-2 packet and decodes the 4-byte packet header, with ECC check and single-bit correction.
- Long packets: forwards exactly the payload words to the unpacker with a qualifying valid. Short packets: decodes them into frame/line strobes.
- Tells the aligner when the packet has ended so it can hunt for the next sync.

---
 rtl/csi_rx_pkg.sv | 35 +++
 rtl/csi_rx_hdr_ecc.sv | 35 +++
 rtl/csi_rx_packet_handler.sv | 184 ++++++++++++++++++
 tb/tb_csi_rx_packet_handler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_rx_pkg.sv
// csi_rx_pkg: shared constants for the CSI-2 receive packet handler
// Data types, FSM encoding, header ECC parity masks and the CRC-16 byte helper.
package csi_rx_pkg;

   localparam logic [5:0] DT_FS       = 6'h00;
   localparam logic [5:0] DT_FE       = 6'h01;
   localparam logic [5:0] DT_LS       = 6'h02;
   localparam logic [5:0] DT_LE       = 6'h03;
   localparam logic [5:0] DT_RAW10    = 6'h2B;
   localparam logic [5:0] DT_LONG_MIN = 6'h10;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_PAYLOAD  = 2'd1;
   localparam logic [1:0] ST_CRC_WAIT = 2'd2;

   // Parity masks P0..P5 over header bits D0..D23; ECC_MASK[k] is Pk
   localparam logic [5:0][23:0] ECC_MASK = {
      24'hEFFC00, 24'hDF03F0, 24'hB8E38E, 24'h749A6D, 24'hF2555B, 24'hF12CB7
   };

   // Reflected CRC-16 (0x1021 -> 0x8408) over the first n bytes of a word, byte0 first
   function automatic logic [15:0] crc16_bytes(input logic [15:0] crc, input logic [31:0] data,
                                               input logic [2:0] n);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) < n) begin
            c = c ^ {8'h00, data[8*i +: 8]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/csi_rx_hdr_ecc.sv
// csi_rx_hdr_ecc: syndrome and single-bit correction for the 24-bit CSI-2 packet header
// A syndrome equal to a data column flips that bit; a one-hot syndrome is an ECC-bit error.
module csi_rx_hdr_ecc
   import csi_rx_pkg::*;
(
   input  logic [23:0] hdr,
   input  logic [5:0]  ecc,
   output logic [23:0] hdr_fixed,
   output logic        corrected,
   output logic        fatal
);

   logic [5:0] syn;
   logic       hit;

   // Recompute parity, locate a flipped data bit by its syndrome column and flip it back
   always_comb begin
      logic [5:0] col;
      col = '0;
      syn = ecc;
      for (int k = 0; k < 6; k++) syn[k] = syn[k] ^ (^(hdr & ECC_MASK[k]));
      hdr_fixed = hdr;
      hit = 1'b0;
      for (int i = 0; i < 24; i++) begin
         for (int k = 0; k < 6; k++) col[k] = ECC_MASK[k][i];
         if (syn == col) begin
            hdr_fixed[i] = ~hdr[i];
            hit = 1'b1;
         end
      end
      corrected = hit || $onehot(syn);
      fatal = (syn != 6'd0) && !corrected;
   end

endmodule

// File: rtl/csi_rx_packet_handler.sv
// csi_rx_packet_handler: CSI-2 header decode with ECC, payload forwarding and short-packet strobes
// Defining CSI_RX_CRC_CHECK_EN adds a CRC-16 payload check and the crc_err output.
module csi_rx_packet_handler
   import csi_rx_pkg::*;
#(
   parameter logic [15:0] MAX_WC    = 16'hFFFF,
   parameter logic [1:0]  VC_FILTER = 2'd0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [31:0] data_in,
   input  logic        din_valid,
   output logic        packet_done,
   output logic [31:0] payload,
   output logic        payload_valid,
   output logic [5:0]  data_type,
   output logic [15:0] word_count,
   output logic        frame_start,
   output logic        frame_end,
   output logic        line_start,
   output logic        line_end,
   output logic        ecc_corrected,
   output logic        ecc_fatal,
`ifdef CSI_RX_CRC_CHECK_EN
   output logic        pkt_abort,
   output logic        crc_err
`else
   output logic        pkt_abort
`endif
);

   logic [1:0]  state;
   logic [14:0] words_left;
   logic [1:0]  vc;
   logic [23:0] hdr_fixed;
   logic        hdr_corrected;
   logic        hdr_fatal;
   logic [5:0]  hdr_dt;
   logic [1:0]  hdr_vc;
   logic [15:0] hdr_wc;
   logic        hdr_long;
   logic        hdr_short_hit;
   logic        wc_bad;
   logic [16:0] wc_round;
   logic        last_word;
   logic        need_wait;
   logic        unused_ok;

   csi_rx_hdr_ecc u_hdr_ecc (
      .hdr       (data_in[23:0]),
      .ecc       (data_in[29:24]),
      .hdr_fixed (hdr_fixed),
      .corrected (hdr_corrected),
      .fatal     (hdr_fatal)
   );

   assign hdr_dt        = hdr_fixed[5:0];
   assign hdr_vc        = hdr_fixed[7:6];
   assign hdr_wc        = hdr_fixed[23:8];
   assign hdr_long      = hdr_dt >= DT_LONG_MIN;
   assign hdr_short_hit = !hdr_long && (hdr_vc == VC_FILTER);
   assign wc_bad        = hdr_long && ({1'b0, hdr_wc} > {1'b0, MAX_WC});
   assign wc_round      = {1'b0, hdr_wc} + 17'd3;
   assign last_word     = words_left == 15'd1;
   assign unused_ok     = ^{data_in[31:30], wc_round[1:0]};

`ifdef CSI_RX_CRC_CHECK_EN
   logic [1:0]  rem;
   logic [15:0] crc_q;
   logic [15:0] crc_word;
   logic [7:0]  crc_lo;
   logic [2:0]  nbytes;
   logic        crc_bad_now;
   logic        crc_bad_wait;

   assign need_wait    = (rem == 2'd0) || (rem == 2'd3);
   assign nbytes       = (last_word && rem != 2'd0) ? {1'b0, rem} : 3'd4;
   assign crc_word     = crc16_bytes(crc_q, data_in, nbytes);
   assign crc_bad_now  = crc_word != ((rem == 2'd1) ? data_in[23:8] : data_in[31:16]);
   assign crc_bad_wait = crc_q != ((rem == 2'd3) ? {data_in[7:0], crc_lo} : data_in[15:0]);

   // Accumulate the payload CRC and flag a mismatch alongside the closing packet_done
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rem     <= '0;
         crc_q   <= '0;
         crc_lo  <= '0;
         crc_err <= 1'b0;
      end else if (!enable) begin
         crc_err <= 1'b0;
      end else begin
         crc_err <= 1'b0;
         if (state == ST_IDLE && din_valid) begin
            crc_q <= 16'hFFFF;
            rem   <= hdr_wc[1:0];
         end
         if (state == ST_PAYLOAD && din_valid) begin
            crc_q   <= crc_word;
            crc_lo  <= data_in[31:24];
            crc_err <= last_word && !need_wait && crc_bad_now;
         end
         if (state == ST_CRC_WAIT && din_valid) crc_err <= crc_bad_wait;
      end
   end
`else
   assign need_wait = 1'b0;
`endif

   // Packet FSM: decode header, stream payload words, raise strobes and completion pulses
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         words_left    <= '0;
         vc            <= '0;
         payload       <= '0;
         payload_valid <= 1'b0;
         data_type     <= '0;
         word_count    <= '0;
         packet_done   <= 1'b0;
         frame_start   <= 1'b0;
         frame_end     <= 1'b0;
         line_start    <= 1'b0;
         line_end      <= 1'b0;
         ecc_corrected <= 1'b0;
         ecc_fatal     <= 1'b0;
         pkt_abort     <= 1'b0;
      end else if (!enable) begin
         {packet_done, payload_valid, frame_start, frame_end, line_start, line_end} <= '0;
         {ecc_corrected, ecc_fatal, pkt_abort} <= '0;
      end else begin
         {packet_done, payload_valid, frame_start, frame_end, line_start, line_end} <= '0;
         {ecc_corrected, ecc_fatal, pkt_abort} <= '0;
         case (state)
            ST_IDLE: begin
               if (din_valid) begin
                  if (hdr_fatal || wc_bad) begin
                     ecc_fatal   <= 1'b1;
                     packet_done <= 1'b1;
                  end else begin
                     data_type     <= hdr_dt;
                     word_count    <= hdr_wc;
                     vc            <= hdr_vc;
                     ecc_corrected <= hdr_corrected;
                     frame_start   <= hdr_short_hit && hdr_dt == DT_FS;
                     frame_end     <= hdr_short_hit && hdr_dt == DT_FE;
                     line_start    <= hdr_short_hit && hdr_dt == DT_LS;
                     line_end      <= hdr_short_hit && hdr_dt == DT_LE;
                     if (!hdr_long || hdr_wc == 16'd0) begin
                        packet_done <= 1'b1;
                     end else begin
                        words_left <= wc_round[16:2];
                        state      <= ST_PAYLOAD;
                     end
                  end
               end
            end
            ST_PAYLOAD: begin
               if (din_valid) begin
                  payload       <= data_in;
                  payload_valid <= vc == VC_FILTER;
                  words_left    <= words_left - 15'd1;
                  if (last_word) begin
                     state       <= need_wait ? ST_CRC_WAIT : ST_IDLE;
                     packet_done <= !need_wait;
                  end
               end else begin
                  pkt_abort   <= 1'b1;
                  packet_done <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            ST_CRC_WAIT: begin
               if (din_valid) begin
                  packet_done <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csi_rx_packet_handler.sv
// tb_csi_rx_packet_handler: scoreboard bench for the CSI-2 packet handler
// Payload words are queued as they are driven and popped as payload_valid appears.
module tb_csi_rx_packet_handler;

   logic        clock;
   logic        reset_n;
   logic        enable;
   logic [31:0] data_in;
   logic        din_valid;
   logic        packet_done;
   logic [31:0] payload;
   logic        payload_valid;
   logic [5:0]  data_type;
   logic [15:0] word_count;
   logic        frame_start;
   logic        frame_end;
   logic        line_start;
   logic        line_end;
   logic        ecc_corrected;
   logic        ecc_fatal;
   logic        pkt_abort;
`ifdef CSI_RX_CRC_CHECK_EN
   logic        crc_err;
`endif

   localparam logic [8:0] E_DONE  = 9'h100;
   localparam logic [8:0] E_FS    = 9'h080;
   localparam logic [8:0] E_FE    = 9'h040;
   localparam logic [8:0] E_LS    = 9'h020;
   localparam logic [8:0] E_LE    = 9'h010;
   localparam logic [8:0] E_CORR  = 9'h008;
   localparam logic [8:0] E_FATAL = 9'h004;
   localparam logic [8:0] E_ABORT = 9'h002;
   localparam logic [8:0] E_PV    = 9'h001;

   logic [8:0]  pulses;
   logic [31:0] exp_q[$];
   logic [31:0] exp_w;
   int          checks = 0;
   int          fails = 0;
   int          n_pv = 0;

   assign pulses = {packet_done, frame_start, frame_end, line_start, line_end,
                    ecc_corrected, ecc_fatal, pkt_abort, payload_valid};

   csi_rx_packet_handler dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable        (enable),
      .data_in       (data_in),
      .din_valid     (din_valid),
      .packet_done   (packet_done),
      .payload       (payload),
      .payload_valid (payload_valid),
      .data_type     (data_type),
      .word_count    (word_count),
      .frame_start   (frame_start),
      .frame_end     (frame_end),
      .line_start    (line_start),
      .line_end      (line_end),
      .ecc_corrected (ecc_corrected),
      .ecc_fatal     (ecc_fatal),
`ifdef CSI_RX_CRC_CHECK_EN
      .pkt_abort     (pkt_abort),
      .crc_err       (crc_err)
`else
      .pkt_abort     (pkt_abort)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Scoreboard: every forwarded payload word must match the oldest queued word
   always @(negedge clock) begin
      if (payload_valid) begin
         n_pv++;
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL payload_unexpected: got %h, none expected", payload);
         end else begin
            exp_w = exp_q.pop_front();
            if (payload !== exp_w) begin
               fails++;
               $display("FAIL payload_word: got %h want %h", payload, exp_w);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Header built from the CSI-2 ECC equations, bits [31:30] zero
   function automatic logic [31:0] mk_hdr(input logic [1:0] v, input logic [5:0] dt, input logic [15:0] wc);
      logic [23:0] d;
      logic [5:0]  p;
      d = {wc, v, dt};
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return {2'b00, p, d};
   endfunction

   // Bit-serial reflected CRC-16/0x1021, seed 0xFFFF, bytes LSB first
   function automatic logic [15:0] crc_model(input logic [7:0] b [16], input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ b[i][j];
            c = {1'b0, c[15:1]};
            if (fb) c = c ^ 16'h8408;
         end
      end
      return c;
   endfunction

   task automatic send(input logic v, input logic [31:0] w);
      din_valid = v;
      data_in = w;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      enable = 1'b1;
      send(1'b1, mk_hdr(2'd0, 6'h00, 16'd1));
      send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd10));
      checks++; if (pulses !== 9'h000) begin fails++; $display("FAIL reset_pulses: got %b want %b", pulses, 9'h000); end
      checks++; if (payload !== 32'd0) begin fails++; $display("FAIL reset_payload: got %h want 0", payload); end
      checks++; if (data_type !== 6'd0) begin fails++; $display("FAIL reset_data_type: got %h want 0", data_type); end
      checks++; if (word_count !== 16'd0) begin fails++; $display("FAIL reset_word_count: got %h want 0", word_count); end
      reset_n = 1'b1;
      send(1'b0, 32'd0);
      checks++; if (pulses !== 9'h000) begin fails++; $display("FAIL reset_release: got %b want %b", pulses, 9'h000); end
   endtask

   task automatic test_short;
      logic [5:0] dts [4] = '{6'h00, 6'h01, 6'h02, 6'h03};
      logic [8:0] exps [4] = '{E_FS, E_FE, E_LS, E_LE};
      for (int i = 0; i < 4; i++) begin
         send(1'b1, mk_hdr(2'd0, dts[i], 16'd1 + 16'(i)));
         checks++; if (pulses !== (E_DONE | exps[i])) begin fails++; $display("FAIL short_strobe_%0d: got %b want %b", i, pulses, E_DONE | exps[i]); end
         checks++; if (data_type !== dts[i]) begin fails++; $display("FAIL short_dt_%0d: got %h want %h", i, data_type, dts[i]); end
         checks++; if (word_count !== 16'd1 + 16'(i)) begin fails++; $display("FAIL short_wc_%0d: got %h want %h", i, word_count, 16'd1 + 16'(i)); end
         send(1'b0, 32'd0);
         checks++; if (pulses !== 9'h000) begin fails++; $display("FAIL short_one_cycle_%0d: got %b want 0", i, pulses); end
      end
      send(1'b1, mk_hdr(2'd1, 6'h00, 16'd7));
      checks++; if (pulses !== E_DONE) begin fails++; $display("FAIL short_other_vc: got %b want %b", pulses, E_DONE); end
      send(1'b0, 32'd0);
   endtask

   task automatic test_long;
      logic [31:0] w;
      send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd10));
      checks++; if (pulses !== 9'h000) begin fails++; $display("FAIL long_hdr_pulses: got %b want 0", pulses); end
      checks++; if (data_type !== 6'h2B) begin fails++; $display("FAIL long_dt: got %h want 2b", data_type); end
      checks++; if (word_count !== 16'd10) begin fails++; $display("FAIL long_wc: got %0d want 10", word_count); end
      for (int i = 0; i < 3; i++) begin
         w = $urandom;
         exp_q.push_back(w);
         send(1'b1, w);
         checks++;
         if (pulses !== ((i == 2) ? (E_DONE | E_PV) : E_PV)) begin
            fails++; $display("FAIL long_word_%0d: got %b want %b", i, pulses, (i == 2) ? (E_DONE | E_PV) : E_PV);
         end
      end
      send(1'b0, 32'd0);
      checks++; if (pulses !== 9'h000) begin fails++; $display("FAIL long_after: got %b want 0", pulses); end
   endtask

   task automatic test_ecc;
      logic [31:0] w;
      send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd6) ^ 32'h0000_0200);
      checks++; if (pulses !== E_CORR) begin fails++; $display("FAIL ecc_single_pulse: got %b want %b", pulses, E_CORR); end
      checks++; if (word_count !== 16'd6) begin fails++; $display("FAIL ecc_single_wc: got %0d want 6", word_count); end
      for (int i = 0; i < 2; i++) begin
         w = $urandom;
         exp_q.push_back(w);
         send(1'b1, w);
      end
      checks++; if (pulses !== (E_DONE | E_PV)) begin fails++; $display("FAIL ecc_single_end: got %b want %b", pulses, E_DONE | E_PV); end
      send(1'b1, mk_hdr(2'd0, 6'h00, 16'd5) ^ 32'h0400_0000);
      checks++; if (pulses !== (E_DONE | E_FS | E_CORR)) begin fails++; $display("FAIL ecc_parity_bit: got %b want %b", pulses, E_DONE | E_FS | E_CORR); end
      send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd6) ^ 32'h0002_0008);
      checks++; if (pulses !== (E_DONE | E_FATAL)) begin fails++; $display("FAIL ecc_double_pulse: got %b want %b", pulses, E_DONE | E_FATAL); end
      checks++; if (word_count !== 16'd5) begin fails++; $display("FAIL ecc_double_wc_held: got %0d want 5", word_count); end
      send(1'b0, 32'd0);
      send(1'b0, 32'd0);
      checks++; if (pulses !== 9'h000) begin fails++; $display("FAIL ecc_double_no_payload: got %b want 0", pulses); end
   endtask

   task automatic test_abort;
      logic [31:0] w;
      send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd40));
      for (int i = 0; i < 5; i++) begin
         w = $urandom;
         exp_q.push_back(w);
         send(1'b1, w);
      end
      checks++; if (pulses !== E_PV) begin fails++; $display("FAIL abort_mid: got %b want %b", pulses, E_PV); end
      send(1'b0, 32'd0);
      checks++; if (pulses !== (E_DONE | E_ABORT)) begin fails++; $display("FAIL abort_pulse: got %b want %b", pulses, E_DONE | E_ABORT); end
      send(1'b1, mk_hdr(2'd0, 6'h02, 16'd0));
      checks++; if (pulses !== (E_DONE | E_LS)) begin fails++; $display("FAIL abort_next_hdr: got %b want %b", pulses, E_DONE | E_LS); end
      send(1'b0, 32'd0);
   endtask

   task automatic test_vc_filter;
      send(1'b1, mk_hdr(2'd1, 6'h2B, 16'd10));
      checks++; if (word_count !== 16'd10) begin fails++; $display("FAIL vc_wc: got %0d want 10", word_count); end
      for (int i = 0; i < 3; i++) send(1'b1, $urandom);
      checks++; if (pulses !== E_DONE) begin fails++; $display("FAIL vc_done_no_pv: got %b want %b", pulses, E_DONE); end
      send(1'b0, 32'd0);
   endtask

   task automatic test_enable;
      logic [31:0] w1;
      logic [31:0] w2;
      w1 = $urandom;
      w2 = $urandom;
      send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd6));
      exp_q.push_back(w1);
      send(1'b1, w1);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b1, $urandom);
      checks++; if (pulses !== 9'h000) begin fails++; $display("FAIL enable_frozen_pulses: got %b want 0", pulses); end
      checks++; if (payload !== w1) begin fails++; $display("FAIL enable_payload_held: got %h want %h", payload, w1); end
      enable = 1'b1;
      exp_q.push_back(w2);
      send(1'b1, w2);
      checks++; if (pulses !== (E_DONE | E_PV)) begin fails++; $display("FAIL enable_resume: got %b want %b", pulses, E_DONE | E_PV); end
      send(1'b1, mk_hdr(2'd0, 6'h00, 16'd3));
      enable = 1'b0;
      send(1'b1, mk_hdr(2'd0, 6'h01, 16'd4));
      checks++; if (pulses !== 9'h000) begin fails++; $display("FAIL enable_pulse_cut: got %b want 0", pulses); end
      checks++; if (word_count !== 16'd3) begin fails++; $display("FAIL enable_wc_held: got %0d want 3", word_count); end
      enable = 1'b1;
      send(1'b0, 32'd0);
   endtask

   task automatic test_back_to_back;
      logic [31:0] w;
      send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd5));
      for (int i = 0; i < 2; i++) begin
         w = $urandom;
         exp_q.push_back(w);
         send(1'b1, w);
      end
      checks++; if (pulses !== (E_DONE | E_PV)) begin fails++; $display("FAIL b2b_end: got %b want %b", pulses, E_DONE | E_PV); end
      send(1'b1, mk_hdr(2'd0, 6'h01, 16'd0));
      checks++; if (pulses !== (E_DONE | E_FE)) begin fails++; $display("FAIL b2b_next_hdr: got %b want %b", pulses, E_DONE | E_FE); end
      send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd0));
      checks++; if (pulses !== E_DONE) begin fails++; $display("FAIL b2b_wc0: got %b want %b", pulses, E_DONE); end
      checks++; if (word_count !== 16'd0) begin fails++; $display("FAIL b2b_wc0_wc: got %0d want 0", word_count); end
      send(1'b0, 32'd0);
   endtask

   task automatic test_reset_mid;
      logic [31:0] w;
      w = $urandom;
      send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd10));
      exp_q.push_back(w);
      send(1'b1, w);
      reset_n = 1'b0;
      send(1'b1, $urandom);
      checks++; if (pulses !== 9'h000) begin fails++; $display("FAIL reset_mid_no_done: got %b want 0", pulses); end
      reset_n = 1'b1;
      send(1'b1, mk_hdr(2'd0, 6'h03, 16'd0));
      checks++; if (pulses !== (E_DONE | E_LE)) begin fails++; $display("FAIL reset_mid_next: got %b want %b", pulses, E_DONE | E_LE); end
      send(1'b0, 32'd0);
   endtask

`ifdef CSI_RX_CRC_CHECK_EN
   task automatic test_crc;
      logic [7:0]  b [16];
      logic [15:0] c8;
      logic [15:0] c6;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
      c8 = crc_model(b, 8);
      c6 = crc_model(b, 6);
      w0 = {b[3], b[2], b[1], b[0]};
      w1 = {b[7], b[6], b[5], b[4]};
      w2 = {16'hA5A5, c8};
      for (int pass = 0; pass < 2; pass++) begin
         send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd8));
         exp_q.push_back(w0);
         send(1'b1, w0);
         exp_q.push_back(w1);
         send(1'b1, w1);
         checks++; if (pulses !== E_PV) begin fails++; $display("FAIL crc_wait_%0d: got %b want %b", pass, pulses, E_PV); end
         send(1'b1, (pass == 1) ? (w2 ^ 32'd1) : w2);
         checks++; if (pulses !== E_DONE) begin fails++; $display("FAIL crc_done_%0d: got %b want %b", pass, pulses, E_DONE); end
         checks++; if (crc_err !== (pass == 1)) begin fails++; $display("FAIL crc_err_%0d: got %b want %b", pass, crc_err, pass == 1); end
         send(1'b0, 32'd0);
      end
      send(1'b1, mk_hdr(2'd0, 6'h2B, 16'd6));
      exp_q.push_back(w0);
      send(1'b1, w0);
      w1 = {c6, b[5], b[4]};
      exp_q.push_back(w1);
      send(1'b1, w1);
      checks++; if (pulses !== (E_DONE | E_PV)) begin fails++; $display("FAIL crc_inline_done: got %b want %b", pulses, E_DONE | E_PV); end
      checks++; if (crc_err !== 1'b0) begin fails++; $display("FAIL crc_inline_err: got %b want 0", crc_err); end
      send(1'b0, 32'd0);
   endtask
`endif

   initial begin
      din_valid = 1'b0;
      data_in = '0;
      test_reset();
      test_short();
      test_long();
      test_ecc();
      test_abort();
      test_vc_filter();
      test_enable();
      test_back_to_back();
      test_reset_mid();
`ifdef CSI_RX_CRC_CHECK_EN
      test_crc();
`endif
      send(1'b0, 32'd0);
      checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d words left want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
